ship_hit_tracker: RTL

// Parametrised per-ship hit tracker; successor to the fixed 12-ship hit counter bank. Holds a length and a

---
 rtl/ship_hit_tracker_if.sv | 43 ++++
 rtl/ship_hit_tracker.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ship_hit_tracker_if.sv
// +----------------------------------------------------------------------------+
// | ship_hit_tracker_if : config / hit / read bundle for ship_hit_tracker       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ship_hit_tracker_if #(
  parameter int NUM_SHIPS = 12,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 3
);
  logic                       clear;
  logic                       cfg_we;
  logic [IDX_W-1:0]           cfg_idx;
  logic [CNT_W-1:0]           cfg_len;
  logic                       hit_we;
  logic [IDX_W-1:0]           hit_idx;
  logic [IDX_W-1:0]           rd_idx;
  logic [CNT_W-1:0]           rd_count;
  logic [CNT_W-1:0]           rd_len;
  logic                       rd_sunk;
  logic [NUM_SHIPS*CNT_W-1:0] hit_counts;
  logic [NUM_SHIPS-1:0]       sunk_vec;
  logic                       sunk_pulse;
  logic [IDX_W-1:0]           sunk_idx;
  logic                       hit_err;
  logic                       all_sunk;
  logic [IDX_W:0]             ships_left;

  modport master (
    output clear, cfg_we, cfg_idx, cfg_len, hit_we, hit_idx, rd_idx,
    input  rd_count, rd_len, rd_sunk, hit_counts, sunk_vec, sunk_pulse,
           sunk_idx, hit_err, all_sunk, ships_left
  );

  modport slave (
    input  clear, cfg_we, cfg_idx, cfg_len, hit_we, hit_idx, rd_idx,
    output rd_count, rd_len, rd_sunk, hit_counts, sunk_vec, sunk_pulse,
           sunk_idx, hit_err, all_sunk, ships_left
  );
endinterface

`default_nettype wire

// File: rtl/ship_hit_tracker.sv
// +----------------------------------------------------------------------------+
// | ship_hit_tracker : per-ship length / saturating hit count / sunk tracking   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ship_hit_tracker #(
  parameter int NUM_SHIPS = 12,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  ship_hit_tracker_if.slave bus
);

  logic [CNT_W-1:0]     len_q [NUM_SHIPS];
  logic [CNT_W-1:0]     len_d [NUM_SHIPS];
  logic [CNT_W-1:0]     cnt_q [NUM_SHIPS];
  logic [CNT_W-1:0]     cnt_d [NUM_SHIPS];
  logic [NUM_SHIPS-1:0] sunk_q, sunk_d;
  logic                 sunk_pulse_q, sunk_pulse_d;
  logic [IDX_W-1:0]     sunk_idx_q, sunk_idx_d;
  logic                 hit_err_q, hit_err_d;
  logic [CNT_W-1:0]     rd_count_q, rd_count_d;
  logic [CNT_W-1:0]     rd_len_q, rd_len_d;
  logic                 rd_sunk_q, rd_sunk_d;
  logic [IDX_W:0]       ships_left;
  logic                 any_used;

  always_comb begin
    len_d        = len_q;
    cnt_d        = cnt_q;
    sunk_d       = sunk_q;
    sunk_pulse_d = 1'b0;
    hit_err_d    = 1'b0;
    sunk_idx_d   = sunk_idx_q;

    if (bus.clear) begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        cnt_d[i] = '0;
      end
      sunk_d = '0;
    end else begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        if (bus.cfg_we && bus.cfg_idx == IDX_W'(i)) begin
          len_d[i]  = bus.cfg_len;
          cnt_d[i]  = '0;
          sunk_d[i] = 1'b0;
        end
      end
      // Assume rejection; only a matching live, in-range slot clears the error.
      if (bus.hit_we) begin
        hit_err_d = 1'b1;
        if (!(bus.cfg_we && bus.cfg_idx == bus.hit_idx)) begin
          for (int i = 0; i < NUM_SHIPS; i++) begin
            if (bus.hit_idx == IDX_W'(i) && len_q[i] != '0 && !sunk_q[i]) begin
              hit_err_d = 1'b0;
              cnt_d[i]  = cnt_q[i] + CNT_W'(1);
              if (cnt_q[i] + CNT_W'(1) == len_q[i]) begin
                sunk_d[i]    = 1'b1;
                sunk_pulse_d = 1'b1;
                sunk_idx_d   = bus.hit_idx;
              end
            end
          end
        end
      end
    end

    // Read port returns the state as it will be after this edge.
    rd_count_d = '0;
    rd_len_d   = '0;
    rd_sunk_d  = 1'b0;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      if (bus.rd_idx == IDX_W'(i)) begin
        rd_count_d = cnt_d[i];
        rd_len_d   = len_d[i];
        rd_sunk_d  = sunk_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SHIPS; i++) begin
        len_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      sunk_q       <= '0;
      sunk_pulse_q <= 1'b0;
      sunk_idx_q   <= '0;
      hit_err_q    <= 1'b0;
      rd_count_q   <= '0;
      rd_len_q     <= '0;
      rd_sunk_q    <= 1'b0;
    end else begin
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      sunk_q       <= sunk_d;
      sunk_pulse_q <= sunk_pulse_d;
      sunk_idx_q   <= sunk_idx_d;
      hit_err_q    <= hit_err_d;
      rd_count_q   <= rd_count_d;
      rd_len_q     <= rd_len_d;
      rd_sunk_q    <= rd_sunk_d;
    end
  end

  always_comb begin
    ships_left = '0;
    any_used   = 1'b0;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      if (len_q[i] != '0) begin
        any_used = 1'b1;
        if (!sunk_q[i]) begin
          ships_left = ships_left + (IDX_W+1)'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SHIPS; g++) begin : g_slot
    assign bus.hit_counts[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign bus.sunk_vec   = sunk_q;
  assign bus.sunk_pulse = sunk_pulse_q;
  assign bus.sunk_idx   = sunk_idx_q;
  assign bus.hit_err    = hit_err_q;
  assign bus.rd_count   = rd_count_q;
  assign bus.rd_len     = rd_len_q;
  assign bus.rd_sunk    = rd_sunk_q;
  assign bus.ships_left = ships_left;
  assign bus.all_sunk   = any_used && (ships_left == '0);

endmodule

`default_nettype wire
